// File: rtl/alu_issue_if.sv
// Bundle between alu_issue_stage and its environment: instruction handshake, yAlu drive/return,
// retired-result side band and the debug register read port.
interface alu_issue_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [2:0]   in_rd;
    logic [2:0]   in_rs;
    logic [2:0]   in_rt;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_z;
    logic         alu_ex;

    logic         out_valid;
    logic [2:0]   out_rd;
    logic [W-1:0] out_data;
    logic         out_ex;
    logic         out_zero;
    logic         out_err;

    logic [2:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt,
        output in_ready,
        output alu_a, alu_b, alu_op,
        input  alu_z, alu_ex,
        output out_valid, out_rd, out_data, out_ex, out_zero, out_err,
        input  dbg_addr,
        output dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt,
        input  in_ready,
        input  alu_a, alu_b, alu_op,
        output alu_z, alu_ex,
        input  out_valid, out_rd, out_data, out_ex, out_zero, out_err,
        output dbg_addr,
        input  dbg_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Three-cycle issue/execute/writeback stage around the combinational yAlu, with an 8 x W
// register file (R0 hardwired to zero) and a combinational debug read port.
module alu_issue_stage #(
    parameter int unsigned W    = 32,
    parameter int unsigned NREG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] rf_q [NREG];
    logic [W-1:0] rf_d [NREG];
    logic [2:0]   rd_q, rd_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic [2:0]   alu_op_q, alu_op_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         out_err_q, out_err_d;
    logic         out_ex_q, out_ex_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [2:0]   out_rd_q, out_rd_d;
    logic         op_legal;

    assign op_legal = alu_op_q inside {3'b000, 3'b001, 3'b010, 3'b110};

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_ex_d    = out_ex_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    // Operands go straight onto the yAlu drive registers for the EXEC cycle.
                    alu_a_d    = rf_q[bus.in_rs];
                    alu_b_d    = rf_q[bus.in_rt];
                    alu_op_d   = bus.in_op;
                    rd_d       = bus.in_rd;
                    in_ready_d = 1'b0;
                    state_d    = StExec;
                end
            end
            StExec: begin
                out_valid_d = 1'b1;
                out_rd_d    = rd_q;
                out_err_d   = ~op_legal;
                out_data_d  = op_legal ? bus.alu_z : '0;
                out_ex_d    = op_legal & bus.alu_ex;
                state_d     = StWb;
            end
            StWb: begin
                if (!out_err_q && rd_q != 3'd0) begin
                    rf_d[rd_q] = out_data_q;
                end
                out_valid_d = 1'b0;
                out_err_d   = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rf_q        <= '{default: '0};
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_ex_q    <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_ex_q    <= out_ex_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ex    = out_ex_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_zero  = (out_data_q == '0);
    assign bus.dbg_data  = (bus.dbg_addr == 3'd0) ? '0 : rf_q[bus.dbg_addr];
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue and writeback stage wrapped around the 32-bit `yAlu` datapath. It accepts register-register ALU instructions over a valid/ready handshake and reads both operands from an internal 8 x 32 register file. It drives the combinational ALU's `a`/`b`/`op` inputs, captures its result `z` and flag `ex`, and writes the result back. A side-band result port and a debug read port let benches check every retired instruction against a software model.

## Interface
- `W`, 32: datapath width; must match the `yAlu` width.
- `NREG`, 8: register count; index width is 3; register 0 is hardwired to zero.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept an instruction.
- `in_op`  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB; all others illegal.
- `in_rd`, `in_rs`, `in_rt`  in  3 each  destination and source register indices.
- `alu_a`, `alu_b`  out  W  operands to `yAlu`.
- `alu_op`  out  3  opcode to `yAlu`.
- `alu_z`  in  W  `yAlu` result, combinational from `alu_a`/`alu_b`/`alu_op`.
- `alu_ex`  in  1  `yAlu` flag.
- `out_valid`  out  1  one-cycle pulse per retired instruction.
- `out_rd`  out  3  destination of the retired instruction.
- `out_data`  out  W  retired result.
- `out_ex`  out  1  `alu_ex` captured with the result.
- `out_zero`  out  1  high when `out_data` == 0.
- `out_err`  out  1  retired instruction had an illegal opcode.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  W  combinational read of register `dbg_addr`; reads 0 for index 0.

## Operation
- The FSM has three states: IDLE, EXEC, WB. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch opcode and `rd`, and latch operands `A`=R[`rs`] and `B`=R[`rt`] from the current register-file contents.
  - Go to EXEC.
- **EXEC**
  - `in_ready`=0.
  - `alu_a`=A, `alu_b`=B, `alu_op`=latched opcode.
  - At the end of the cycle: capture `alu_z` into the result register and `alu_ex` into the flag register.
  - Go to WB.
- **WB**
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` = captured result, `out_ex` = captured flag, `out_rd` = latched `rd`.
  - If the opcode is legal and `rd`!=0: R[`rd`] ← result at the end of the cycle.
  - Go to IDLE.
- **Illegal opcode**
  - The instruction still walks through EXEC and WB.
  - In WB: `out_err`=1, `out_data`=0, `out_ex`=0, and nothing is written.
- **Outside EXEC:** `alu_a`, `alu_b`, `alu_op` hold their last driven values; do not rely on them.
- **Width rules:** ADD and SUB wrap modulo 2^32. The stage never inspects `alu_ex` beyond registering it.
- **No hazards:** writeback completes before the next IDLE read, so back-to-back dependent instructions see the new value.
- **Reset (async, any state):**
  - FSM returns to IDLE and all registers R0..R7 become 0.
  - The result, flag and latched fields clear.
  - An in-flight instruction is discarded with no write and no `out_valid`.
- **Reset output values:**
  - `in_ready`=1 after reset.
  - `out_valid`=0, `out_err`=0, `out_ex`=0, `out_data`=0, `out_rd`=0, `out_zero`=1.
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.

## Timing
- Accept at rising edge T.
- EXEC occupies cycle T..T+1; the result is captured at edge T+1.
- `out_valid` is high during cycle T+1..T+2; the register write takes effect at edge T+2.
- Earliest next accept is edge T+3 (`in_ready` returns high after edge T+2). Throughput is 1 instruction per 3 cycles.
- `yAlu` must settle within one clock period (combinational path `alu_a` → `alu_z` → result register).
- `dbg_data` reflects a writeback one edge after WB, i.e. from edge T+2 onward.
- `in_valid` asserted while `in_ready`=0 is ignored; the instruction is not captured and the source must hold it.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC of an ADD targeting R3 -> no `out_valid`; `dbg_data`(R3)=0; `in_ready`=1; `out_zero`=1.
- **Seed and ADD:**
  - Load values via ADDs from R0: R1=0 since 0+0; each result goes through the model.
  - Backdoor is forbidden, so chain ORs/ADDs to build R1=5 and R2=3.
  - Issue ADD R4=R1+R2 -> `out_data`=8, `out_zero`=0, `dbg_data`(R4)=8 from edge T+2.
- **SUB wrap:** SUB R5=R2-R1 with 3,5 -> `out_data`=0xFFFFFFFE. Then SUB R6=R1-R1 -> `out_data`=0, `out_zero`=1.
- **AND/OR:** with R1=0xF0F0F0F0 and R2=0xFF00FF00, AND -> 0xF000F000 and OR -> 0xFFF0FFF0. Compare against the model `expect` for 10 random operand pairs.
- **R0 and illegal op:**
  - ADD rd=0 -> `out_valid` pulses, but `dbg_data`(R0) stays 0.
  - op=011 -> `out_err`=1, `out_data`=0, no register changes.
- **Handshake and dependency:**
  - Hold `in_valid`=1 continuously with ADD R1=R1+R1 starting from R1=1 -> `out_valid` exactly every 3 cycles.
  - `out_data` sequence is 2, 4, 8, 16.
  - No instruction is dropped or duplicated.
